dbg_scan_action_ctrl: RTL and testbench

//  Parametrised debug scan controller between the virtual-JTAG phy and the CPU debug core.
//  - Runs entirely on the system clock; the phy delivers TCK edges as pre-synchronised strobes.
//  - Shifts a DR_W-bit data register and latches jdo on update-DR.
//  - Decodes the IR code into one of N_CH action channels and issues a one-cycle take_action or take_no_action pulse.
//  - Holds the pulse pending until the core accepts it; flags overrun.

---
 rtl/dbg_scan_pkg.sv | 22 ++
 rtl/dbg_scan_shreg.sv | 63 ++++++
 rtl/dbg_scan_action_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_dbg_scan_action_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_scan_pkg.sv
// rtl/dbg_scan_pkg.sv - shared FSM states, field constants and parity helper for the debug scan controller
// Optional feature macro: DBG_SCAN_PARITY_EN (parity_even() is only called when it is defined).
package dbg_scan_pkg;

  // FSM encoding; ST_PEND is "idle with an undelivered update".
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CAP   = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_UPD   = 3'd3;
  localparam logic [2:0] ST_PEND  = 3'd4;

  // Field positions are counted down from the DR MSB so they follow DR_W.
  localparam int         ACTION_BIT   = 0;      // jdo[DR_W-1-ACTION_BIT] = action request
  localparam int         OVR_CLR_MSB  = 1;      // jdo[DR_W-2 -: 2] = overrun clear field
  localparam logic [1:0] OVR_CLR_CODE = 2'b11;

  // Even-parity bit for up to 64 data bits (callers zero-extend).
  function automatic logic parity_even(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/dbg_scan_shreg.sv
// rtl/dbg_scan_shreg.sv - debug data register with capture, shift, clear and serial tdo
// Optional feature macro: DBG_SCAN_PARITY_EN adds an even-parity MSB to the register.
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   load           capture cap_data (plus parity bit when enabled)
//   shift          shift right by one, tdi enters at the MSB
//   clear          zero the register (highest priority)
//   tdi            serial input
//   cap_data       DR_W-bit capture word
//   data           current DR_W data bits of the register
//   parity_ok      (macro only) stored parity bit matches the data bits
//   tdo            serial output = register bit 0
module dbg_scan_shreg #(
  parameter int DR_W = 38
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            shift,
  input  logic            clear,
  input  logic            tdi,
  input  logic [DR_W-1:0] cap_data,
  output logic [DR_W-1:0] data,
`ifdef DBG_SCAN_PARITY_EN
  output logic            parity_ok,
`endif
  output logic            tdo
);
  import dbg_scan_pkg::*;

`ifdef DBG_SCAN_PARITY_EN
  localparam int SR_W = DR_W + 1;
`else
  localparam int SR_W = DR_W;
`endif

  logic [SR_W-1:0] sr_q, sr_d;
  logic [SR_W-1:0] cap_word;

  always_comb begin
`ifdef DBG_SCAN_PARITY_EN
    cap_word = {parity_even(64'(cap_data)), cap_data};
`else
    cap_word = cap_data;
`endif
    sr_d = sr_q;
    if (clear)      sr_d = '0;
    else if (load)  sr_d = cap_word;
    else if (shift) sr_d = {tdi, sr_q[SR_W-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign data = sr_q[DR_W-1:0];
  assign tdo  = sr_q[0];
`ifdef DBG_SCAN_PARITY_EN
  assign parity_ok = (sr_q[DR_W] == parity_even(64'(sr_q[DR_W-1:0])));
`endif

endmodule

// File: rtl/dbg_scan_action_ctrl.sv
// rtl/dbg_scan_action_ctrl.sv - debug scan controller: DR shift, update latch and per-channel action pulses
// Optional feature macro: DBG_SCAN_PARITY_EN (parity-protected DR, adds parity_err output).
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   tck_en                     one-cycle strobe per TCK rising edge
//   tdi / tdo                  serial data in / out
//   vs_cdr, vs_sdr, vs_udr,    capture-DR, shift-DR, update-DR, update-IR states
//   vs_uir
//   ir_in                      current instruction, selects the action channel
//   capture_data               per-channel capture words, DR_W bits each
//   action_ready               per-channel accept signal from the core
//   jdo                        data latched at update
//   take_action/take_no_action one-cycle pulse on the addressed channel
//   pending                    an update is waiting for action_ready
//   overrun                    sticky: an update arrived while one was pending
//   parity_err                 (macro only) sticky: update had bad parity
module dbg_scan_action_ctrl #(
  parameter int DR_W = 38,
  parameter int IR_W = 2,
  parameter int N_CH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tck_en,
  input  logic                 tdi,
  input  logic                 vs_cdr,
  input  logic                 vs_sdr,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [N_CH*DR_W-1:0] capture_data,
  input  logic [N_CH-1:0]      action_ready,
  output logic                 tdo,
  output logic [DR_W-1:0]      jdo,
  output logic [N_CH-1:0]      take_action,
  output logic [N_CH-1:0]      take_no_action,
  output logic                 pending,
`ifdef DBG_SCAN_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);
  import dbg_scan_pkg::*;

  logic [2:0]      state_q, state_d, rest_state;
  logic [IR_W-1:0] ch_q, ch_d, pend_ch_q, pend_ch_d, fire_ch;
  logic [DR_W-1:0] jdo_q, jdo_d, cap_sel, sr_data;
  logic [N_CH-1:0] take_action_q, take_action_d, take_no_action_q, take_no_action_d;
  logic            pending_q, pending_d, overrun_q, overrun_d;
  logic            sr_load, sr_shift, sr_clear;
  logic            ch_ok, upd_ready, pend_ready, fire, fire_act;
  logic            parity_ok;
`ifdef DBG_SCAN_PARITY_EN
  logic            parity_err_q, parity_err_d;
`endif

  dbg_scan_shreg #(.DR_W(DR_W)) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (sr_load),
    .shift     (sr_shift),
    .clear     (sr_clear),
    .tdi       (tdi),
    .cap_data  (cap_sel),
    .data      (sr_data),
`ifdef DBG_SCAN_PARITY_EN
    .parity_ok (parity_ok),
`endif
    .tdo       (tdo)
  );

`ifndef DBG_SCAN_PARITY_EN
  assign parity_ok = 1'b1;
`endif

  // Channel decode by loop so out-of-range IR codes simply match nothing.
  always_comb begin
    cap_sel    = '0;
    ch_ok      = 1'b0;
    upd_ready  = 1'b0;
    pend_ready = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ir_in == IR_W'(i)) cap_sel = capture_data[i*DR_W +: DR_W];
      if (ch_q == IR_W'(i)) begin
        ch_ok     = 1'b1;
        upd_ready = action_ready[i];
      end
      if (pend_ch_q == IR_W'(i)) pend_ready = pending_q & action_ready[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    pend_ch_d = pend_ch_q;
    jdo_d     = jdo_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
`ifdef DBG_SCAN_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_clear  = 1'b0;
    fire      = 1'b0;
    fire_ch   = pend_ch_q;
    fire_act  = jdo_q[DR_W-1-ACTION_BIT];

    // A pending update is delivered independently of the scan in progress.
    if (pend_ready) begin
      fire      = 1'b1;
      pending_d = 1'b0;
    end
    rest_state = pending_d ? ST_PEND : ST_IDLE;

    case (state_q)
      ST_IDLE, ST_PEND: begin
        state_d = rest_state;
        if (tck_en) begin
          if (vs_uir && state_q == ST_IDLE) sr_clear = 1'b1;
          else if (vs_cdr) begin
            sr_load = 1'b1;
            state_d = ST_CAP;
          end
        end
      end
      ST_CAP, ST_SHIFT: begin
        if (tck_en) begin
          if (vs_uir) begin
            sr_clear = 1'b1;
            state_d  = rest_state;
          end else if (vs_cdr) begin
            sr_load = 1'b1;
            state_d = ST_CAP;
          end else if (vs_sdr) begin
            sr_shift = 1'b1;
            state_d  = ST_SHIFT;
          end else if (vs_udr && state_q == ST_SHIFT) begin
            ch_d    = ir_in;
            state_d = ST_UPD;
          end
        end
      end
      ST_UPD: begin
        state_d = rest_state;
        if (pending_q) begin
          // The held update wins; the new register contents are dropped.
          overrun_d = 1'b1;
        end else if (ch_ok) begin
          if (!parity_ok) begin
`ifdef DBG_SCAN_PARITY_EN
            parity_err_d = 1'b1;
`endif
          end else begin
            jdo_d = sr_data;
            if (sr_data[DR_W-1-OVR_CLR_MSB -: 2] == OVR_CLR_CODE) overrun_d = 1'b0;
            if (upd_ready) begin
              fire     = 1'b1;
              fire_ch  = ch_q;
              fire_act = sr_data[DR_W-1-ACTION_BIT];
            end else begin
              pending_d = 1'b1;
              pend_ch_d = ch_q;
              state_d   = ST_PEND;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only one source fires per cycle, so at most one pulse bit is set.
    take_action_d    = '0;
    take_no_action_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (fire && fire_ch == IR_W'(i)) begin
        take_action_d[i]    = fire_act;
        take_no_action_d[i] = ~fire_act;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      ch_q             <= '0;
      pend_ch_q        <= '0;
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      pending_q        <= 1'b0;
      overrun_q        <= 1'b0;
`ifdef DBG_SCAN_PARITY_EN
      parity_err_q     <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      ch_q             <= ch_d;
      pend_ch_q        <= pend_ch_d;
      jdo_q            <= jdo_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      pending_q        <= pending_d;
      overrun_q        <= overrun_d;
`ifdef DBG_SCAN_PARITY_EN
      parity_err_q     <= parity_err_d;
`endif
    end
  end

  assign jdo            = jdo_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign pending        = pending_q;
  assign overrun        = overrun_q;
`ifdef DBG_SCAN_PARITY_EN
  assign parity_err     = parity_err_q;
`endif

endmodule

// File: tb/tb_dbg_scan_action_ctrl.sv
// tb/tb_dbg_scan_action_ctrl.sv - scoreboard bench for dbg_scan_action_ctrl (optional DBG_SCAN_PARITY_EN)
module tb_dbg_scan_action_ctrl;
  localparam int DR_W = 38;
  localparam int IR_W = 2;
  localparam int N_CH = 3;
`ifdef DBG_SCAN_PARITY_EN
  localparam int SR_W = DR_W + 1;
`else
  localparam int SR_W = DR_W;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 tck_en, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir;
  logic [IR_W-1:0]      ir_in;
  logic [N_CH*DR_W-1:0] capture_data;
  logic [N_CH-1:0]      action_ready;
  logic                 tdo, pending, overrun;
  logic [DR_W-1:0]      jdo;
  logic [N_CH-1:0]      take_action, take_no_action;
`ifdef DBG_SCAN_PARITY_EN
  logic                 parity_err;
`endif

  always #5 clk = ~clk;

  dbg_scan_action_ctrl #(.DR_W(DR_W), .IR_W(IR_W), .N_CH(N_CH)) dut (
    .clk            (clk),
    .reset          (reset),
    .tck_en         (tck_en),
    .tdi            (tdi),
    .vs_cdr         (vs_cdr),
    .vs_sdr         (vs_sdr),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .capture_data   (capture_data),
    .action_ready   (action_ready),
    .tdo            (tdo),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .pending        (pending),
`ifdef DBG_SCAN_PARITY_EN
    .parity_err     (parity_err),
`endif
    .overrun        (overrun)
  );

  typedef struct packed {
    logic [IR_W-1:0] ch;
    logic            act;
  } pulse_t;

  pulse_t exp_pulse[$];
  logic   exp_tdo[$];
  int     n_pass = 0;
  int     n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scan word as it sits in the DR: data plus even parity when enabled.
  function automatic logic [SR_W-1:0] word(input logic [DR_W-1:0] d);
`ifdef DBG_SCAN_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Monitor: tdo stream and action pulses against the scoreboard queues.
  pulse_t            mon_p;
  logic [2*N_CH-1:0] mon_ev;
  always @(negedge clk) begin
    if (!reset) begin
      if (tck_en && vs_sdr) begin
        if (exp_tdo.size() == 0) check("tdo_unexpected_shift", 64'd1, 64'd0);
        else check("tdo_stream", {63'd0, tdo}, {63'd0, exp_tdo.pop_front()});
      end
      if (|take_action || |take_no_action) begin
        if (exp_pulse.size() == 0) begin
          check("pulse_unexpected", {take_action, take_no_action}, 64'd0);
        end else begin
          mon_p  = exp_pulse.pop_front();
          mon_ev = '0;
          if (mon_p.act) mon_ev[N_CH + int'(mon_p.ch)] = 1'b1;
          else           mon_ev[int'(mon_p.ch)] = 1'b1;
          check("pulse", {take_action, take_no_action}, mon_ev);
        end
      end
    end
  end

  task automatic strobe(input logic cdr, input logic sdr, input logic udr, input logic uir, input logic d);
    vs_cdr = cdr; vs_sdr = sdr; vs_udr = udr; vs_uir = uir; tdi = d; tck_en = 1'b1;
    @(posedge clk); #1;
    tck_en = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; tdi = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic scan(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] cap,
                      input logic [SR_W-1:0] shin, input int nbits);
    ir_in = ir;
    strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      exp_tdo.push_back(cap[i]);
      strobe(1'b0, 1'b1, 1'b0, 1'b0, shin[i]);
    end
  endtask

  task automatic do_update();
    strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  localparam logic [DR_W-1:0] C0 = 38'h01_0000_0001;
  localparam logic [DR_W-1:0] C1 = 38'h15_5555_5555;
  localparam logic [DR_W-1:0] C2 = 38'h2A_0F0F_F0F0;
  localparam logic [DR_W-1:0] D1 = 38'h20_0000_00AA;
  localparam logic [DR_W-1:0] D2 = 38'h00_1234_5678;
  localparam logic [DR_W-1:0] D2B = 38'h00_0000_0F0F;
  localparam logic [DR_W-1:0] D3 = 38'h3F_FFFF_0000;
  localparam logic [DR_W-1:0] D4 = 38'h18_0000_0001;

  int pend_cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tck_en = 1'b0; tdi = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0;
    vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; action_ready = 3'b111;
    capture_data = {C2, C1, C0};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    check("rst_tdo", {63'd0, tdo}, 64'd0);
    check("rst_jdo", jdo, 64'd0);
    check("rst_pulses", {take_action, take_no_action}, 64'd0);
    check("rst_pending", {63'd0, pending}, 64'd0);
    check("rst_overrun", {63'd0, overrun}, 64'd0);
`ifdef DBG_SCAN_PARITY_EN
    check("rst_parity_err", {63'd0, parity_err}, 64'd0);
`endif

    // 1: ch1 ready, action bit set, 2-clk latency, single pulse
    scan(2'd1, word(C1), word(D1), SR_W);
    exp_pulse.push_back('{ch: 2'd1, act: 1'b1});
    vs_udr = 1'b1; tck_en = 1'b1;
    @(posedge clk); #1;
    vs_udr = 1'b0; tck_en = 1'b0;
    check("t1_no_pulse_1clk", {take_action, take_no_action}, 64'd0);
    @(posedge clk); #1;
    check("t1_pulse_2clk", {take_action, take_no_action}, {3'b010, 3'b000});
    check("t1_jdo", jdo, D1);
    @(posedge clk); #1;
    check("t1_pulse_gone", {take_action, take_no_action}, 64'd0);

    // 2: ch2 not ready for 10 clk, then take_no_action[2]
    action_ready = 3'b011;
    scan(2'd2, word(C2), word(D2), SR_W);
    do_update();
    check("t2_pending_set", {63'd0, pending}, 64'd1);
    check("t2_jdo", jdo, D2);
    pend_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (pending) pend_cnt++;
    end
    check("t2_pending_10clk", pend_cnt, 64'd10);
    exp_pulse.push_back('{ch: 2'd2, act: 1'b0});
    action_ready = 3'b111;
    @(posedge clk); #1;
    check("t2_pending_cleared", {63'd0, pending}, 64'd0);
    @(posedge clk); #1;

    // 3: second update while pending -> overrun, data kept, one pulse
    action_ready = 3'b011;
    scan(2'd2, word(C2), word(D2B), SR_W);
    do_update();
    scan(2'd2, word(C2), word(D3), SR_W);
    do_update();
    check("t3_overrun", {63'd0, overrun}, 64'd1);
    check("t3_jdo_kept", jdo, D2B);
    check("t3_still_pending", {63'd0, pending}, 64'd1);
    exp_pulse.push_back('{ch: 2'd2, act: 1'b0});
    action_ready = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check("t3_pending_cleared", {63'd0, pending}, 64'd0);
    check("t3_overrun_sticky", {63'd0, overrun}, 64'd1);
    scan(2'd1, word(C1), word(D4), SR_W);
    exp_pulse.push_back('{ch: 2'd1, act: 1'b0});
    do_update();
    check("t3_overrun_clear", {63'd0, overrun}, 64'd0);
    check("t3_jdo_clear_word", jdo, D4);

    // 4: reset after 17 shifted bits, then a normal scan
    capture_data[DR_W +: DR_W] = 38'h2A_AAAA_AAAA;
    scan(2'd1, word(38'h2A_AAAA_AAAA), word(D1), 17);
    check("t4_tdo_before_reset", {63'd0, tdo}, 64'd1);
    reset = 1'b1;
    #1;
    check("t4_rst_outputs", {tdo, pending, overrun, take_action, take_no_action}, 64'd0);
    check("t4_rst_jdo", jdo, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    capture_data[DR_W +: DR_W] = C1;
    @(posedge clk); #1;
    scan(2'd1, word(C1), word(D1), SR_W);
    exp_pulse.push_back('{ch: 2'd1, act: 1'b1});
    do_update();
    check("t4_jdo_after", jdo, D1);

    // 5: IR code beyond N_CH captures 0 and never pulses
    scan(2'd3, '0, word(38'h3F_FFFF_FFFF), SR_W);
    do_update();
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_pending", {63'd0, pending}, 64'd0);

`ifdef DBG_SCAN_PARITY_EN
    // 6: flipped parity bit suppresses update, good parity still pulses
    scan(2'd1, word(C1), word(38'h20_0000_0003) ^ (39'd1 << DR_W), SR_W);
    do_update();
    check("t6_parity_err", {63'd0, parity_err}, 64'd1);
    check("t6_jdo_unchanged", jdo, D1);
    scan(2'd1, word(C1), word(38'h20_0000_0003), SR_W);
    exp_pulse.push_back('{ch: 2'd1, act: 1'b1});
    do_update();
    check("t6_jdo_good", jdo, 38'h20_0000_0003);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("pulse_queue_empty", exp_pulse.size(), 64'd0);
    check("tdo_queue_empty", exp_tdo.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
